// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, line levels, defaults and a counter-width helper.
// Used by uart_tx, uart_bit_timer and uart_rx.
package uart_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_START = ST_START,
      S_DATA  = ST_DATA,
      S_STOP  = ST_STOP
   } uart_state_e;

   localparam logic UART_IDLE_LVL  = 1'b1;
   localparam logic UART_START_LVL = 1'b0;

   localparam int UART_DATA_BITS    = 8;
   localparam int UART_CLKS_PER_BIT = 1;

   // Counter width for a modulus n, never narrower than one bit
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, wraps, and flags the last clock.
// i_load clears the count; o_bit_done is high during the final clock of each bit.
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int CW           = cnt_width(CLKS_PER_BIT)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_load,
   input  logic          i_en,
   output logic [CW-1:0] o_cnt,
   output logic          o_bit_done
);

   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] ZERO = {CW{1'b0}};

   logic [CW-1:0] r_cnt;

   assign o_cnt      = r_cnt;
   assign o_bit_done = i_en & (r_cnt == LAST);

   // Bit-period counter with clear and wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= ZERO;
      end else if (i_load) begin
         r_cnt <= ZERO;
      end else if (i_en) begin
         if (r_cnt == LAST) begin
            r_cnt <= ZERO;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end else begin
         r_cnt <= r_cnt;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1-style UART transmitter with valid/ready input and registered serial/busy outputs.
// Back-to-back frames are accepted in the final stop-bit clock, so there is no idle gap.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int DATA_BITS    = UART_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx_serial,
   output logic                 tx_busy
);

   localparam int CW = cnt_width(CLKS_PER_BIT);
   localparam int BW = cnt_width(DATA_BITS);
   localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   uart_state_e            r_state;
   logic [DATA_BITS-1:0]   r_shift;
   logic [BW-1:0]          r_bit_cnt;
   logic                   r_serial;
   logic                   r_busy;

   logic [CW-1:0]          w_cnt;
   logic                   w_bit_done;
   logic                   w_idle;
   logic                   w_ready;
   logic                   w_accept;

   assign w_idle   = (r_state == S_IDLE);
   assign w_ready  = w_idle | ((r_state == S_STOP) & (w_cnt == LAST_CLK));
   assign w_accept = tx_valid & w_ready;

   assign tx_ready  = w_ready;
   assign tx_serial = r_serial;
   assign tx_busy   = r_busy;

   // Timer is held clear in IDLE so every frame starts from a fresh bit period
   uart_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .CW           (CW)
   ) u_timer (
      .clk        (clk),
      .rst_n      (reset),
      .i_load     (w_idle),
      .i_en       (~w_idle),
      .o_cnt      (w_cnt),
      .o_bit_done (w_bit_done)
   );

   // Frame sequencer: shift register, bit counter and registered line/busy outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_shift   <= {DATA_BITS{1'b0}};
         r_bit_cnt <= {BW{1'b0}};
         r_serial  <= UART_IDLE_LVL;
         r_busy    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_shift  <= tx_data;
                  r_state  <= S_START;
                  r_serial <= UART_START_LVL;
                  r_busy   <= 1'b1;
               end else begin
                  r_serial <= UART_IDLE_LVL;
                  r_busy   <= 1'b0;
               end
            end
            S_START: begin
               if (w_bit_done) begin
                  r_state   <= S_DATA;
                  r_serial  <= r_shift[0];
                  r_bit_cnt <= {BW{1'b0}};
               end
            end
            S_DATA: begin
               if (w_bit_done) begin
                  if (r_bit_cnt == LAST_BIT) begin
                     r_state  <= S_STOP;
                     r_serial <= UART_IDLE_LVL;
                  end else begin
                     // Next bit comes from position 1 because the shift lands on this same edge
                     r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
                     r_serial  <= r_shift[1];
                     r_bit_cnt <= r_bit_cnt + BW'(1);
                  end
               end
            end
            S_STOP: begin
               if (w_bit_done) begin
                  if (w_accept) begin
                     r_shift  <= tx_data;
                     r_state  <= S_START;
                     r_serial <= UART_START_LVL;
                     r_busy   <= 1'b1;
                  end else begin
                     r_state  <= S_IDLE;
                     r_serial <= UART_IDLE_LVL;
                     r_busy   <= 1'b0;
                  end
               end
            end
            default: begin
               r_state  <= S_IDLE;
               r_serial <= UART_IDLE_LVL;
               r_busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: two instances (1 and 4 clocks per bit) checked against a
// frame-level reference model, plus a line decoder that recovers bytes from the serial output.
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] d1, d4;
   logic       v1, v4;
   logic       r1, s1, b1;
   logic       r4, s4, b4;

   int checks = 0;
   int errors = 0;

   logic [7:0] tx_q[$];
   logic       line_q[$];

   always #5 clk = ~clk;

   uart_tx #(.CLKS_PER_BIT(1), .DATA_BITS(8)) u1 (
      .clk(clk), .reset(reset), .tx_data(d1), .tx_valid(v1),
      .tx_ready(r1), .tx_serial(s1), .tx_busy(b1)
   );

   uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8)) u4 (
      .clk(clk), .reset(reset), .tx_data(d4), .tx_valid(v4),
      .tx_ready(r4), .tx_serial(s4), .tx_busy(b4)
   );

   // Reference frame: bit 0 start, bits 1..8 data LSB first, bit 9 stop
   function automatic logic [9:0] frame_of(input logic [7:0] b);
      return {1'b1, b, 1'b0};
   endfunction

   task automatic drive(input int sel, input logic [7:0] data, input logic valid);
      if (sel == 1) begin
         d1 = data; v1 = valid;
      end else begin
         d4 = data; v4 = valid;
      end
   endtask

   task automatic observe(input int sel, output logic ser, output logic rdy, output logic bsy,
                          output logic vld);
      if (sel == 1) begin
         ser = s1; rdy = r1; bsy = b1; vld = v1;
      end else begin
         ser = s4; rdy = r4; bsy = b4; vld = v4;
      end
   endtask

   // Sends every byte in tx_q, keeping tx_valid high, and checks the line clock by clock
   task automatic run_stream(input int sel, input int cpb, input string name);
      logic exp_q[$];
      logic [9:0] f;
      logic ser, rdy, bsy, vld, acc, exp_rdy;
      int total, idx, fl;
      fl = 10 * cpb;
      total = tx_q.size() * fl;
      foreach (tx_q[i]) begin
         f = frame_of(tx_q[i]);
         for (int b = 0; b < 10; b++)
            for (int c = 0; c < cpb; c++)
               exp_q.push_back(f[b]);
      end
      line_q.delete();
      idx = 0;
      @(negedge clk);
      drive(sel, tx_q[0], 1'b1);
      for (int t = 0; t < total; t++) begin
         observe(sel, ser, rdy, bsy, vld);
         acc = rdy & vld;
         @(negedge clk);
         if (acc) begin
            idx++;
            if (idx < tx_q.size()) drive(sel, tx_q[idx], 1'b1);
            else drive(sel, 8'($urandom), 1'b0);
         end
         observe(sel, ser, rdy, bsy, vld);
         line_q.push_back(ser);
         exp_rdy = ((t % fl) == fl - 1);
         checks++;
         if (ser !== exp_q[t]) begin
            errors++;
            $display("FAIL %s line t=%0d got %b exp %b", name, t, ser, exp_q[t]);
         end
         checks++;
         if (rdy !== exp_rdy) begin
            errors++;
            $display("FAIL %s ready t=%0d got %b exp %b", name, t, rdy, exp_rdy);
         end
         checks++;
         if (bsy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy t=%0d got %b exp 1", name, t, bsy);
         end
      end
      checks++;
      if (idx != tx_q.size()) begin
         errors++;
         $display("FAIL %s accepted got %0d exp %0d", name, idx, tx_q.size());
      end
      drive(sel, 8'bx, 1'b0);
      @(negedge clk);
      observe(sel, ser, rdy, bsy, vld);
      checks++;
      if ({ser, rdy, bsy} !== 3'b110) begin
         errors++;
         $display("FAIL %s idle_after ser/rdy/busy got %b%b%b exp 110", name, ser, rdy, bsy);
      end
   endtask

   // Recovers bytes from line_q like a receiver would (mid-bit sampling) and compares with tx_q
   task automatic decode_check(input int cpb, input string name);
      logic [7:0] rx_q[$];
      logic [7:0] b;
      int i;
      i = 0;
      while (i + 10 * cpb <= line_q.size()) begin
         if (line_q[i] == 1'b0) begin
            for (int k = 0; k < 8; k++) b[k] = line_q[i + cpb * (1 + k) + cpb / 2];
            if (line_q[i + cpb * 9 + cpb / 2] == 1'b1) rx_q.push_back(b);
            i += 10 * cpb;
         end else begin
            i++;
         end
      end
      checks++;
      if (rx_q.size() != tx_q.size()) begin
         errors++;
         $display("FAIL %s rx_count got %0d exp %0d", name, rx_q.size(), tx_q.size());
      end else begin
         foreach (tx_q[j]) begin
            checks++;
            if (rx_q[j] !== tx_q[j]) begin
               errors++;
               $display("FAIL %s rx_byte[%0d] got %h exp %h", name, j, rx_q[j], tx_q[j]);
            end
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      drive(1, 8'($urandom), 1'b1);
      drive(4, 8'($urandom), 1'b1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if ({s1, r1, b1, s4, r4, b4} !== 6'b110110) begin
            errors++;
            $display("FAIL reset c=%0d got %b%b%b %b%b%b exp 110 110", c, s1, r1, b1, s4, r4, b4);
         end
      end
      drive(1, 8'bx, 1'b0);
      drive(4, 8'bx, 1'b0);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({s1, r1, b1, s4, r4, b4} !== 6'b110110) begin
         errors++;
         $display("FAIL reset_release got %b%b%b %b%b%b exp 110 110", s1, r1, b1, s4, r4, b4);
      end
   endtask

   task automatic test_single();
      tx_q = '{8'hA5};
      run_stream(1, 1, "single_a5");
   endtask

   task automatic test_back_to_back();
      tx_q = '{8'h00, 8'hFF};
      run_stream(1, 1, "b2b_00_ff");
   endtask

   task automatic test_slow_bits();
      tx_q = '{8'h3C};
      run_stream(4, 4, "cpb4_3c");
      tx_q = '{8'($urandom), 8'($urandom)};
      run_stream(4, 4, "cpb4_b2b");
      decode_check(4, "cpb4_decode");
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      drive(1, 8'h55, 1'b1);
      @(negedge clk);
      drive(1, 8'bx, 1'b0);
      repeat (4) @(negedge clk);
      checks++;
      if ({s1, b1} !== 2'b01) begin
         errors++;
         $display("FAIL midrst_bit3 ser/busy got %b%b exp 01", s1, b1);
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({s1, r1, b1} !== 3'b110) begin
         errors++;
         $display("FAIL midrst_async ser/rdy/busy got %b%b%b exp 110", s1, r1, b1);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      tx_q = '{8'h81};
      run_stream(1, 1, "after_rst_81");
   endtask

   task automatic test_loopback();
      tx_q = '{8'h00, 8'h55, 8'hAA, 8'hFF};
      run_stream(1, 1, "loop_fixed");
      decode_check(1, "loop_fixed_decode");
   endtask

   task automatic test_random();
      int n;
      for (int r = 0; r < 6; r++) begin
         n = 1 + int'($urandom_range(3));
         tx_q.delete();
         for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom));
         run_stream(1, 1, "rand_cpb1");
         decode_check(1, "rand_cpb1_decode");
         run_stream(4, 4, "rand_cpb4");
         decode_check(4, "rand_cpb4_decode");
         repeat ($urandom_range(3)) @(negedge clk);
      end
   endtask

   initial begin
      reset = 1'b0;
      d1 = 8'h00; v1 = 1'b0;
      d4 = 8'h00; v4 = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_slow_bits();
      test_mid_reset();
      test_loopback();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
